// File: rtl/prism_cap_pkg.sv
// Shared constants and entry layout for the PRISM output capture block.
// An entry is the captured output word plus the timestamp at which it changed.
package prism_cap_pkg;

  localparam int CAP_DATA_W = 11;
  localparam int CAP_TS_W   = 16;

  // Bit positions inside the 32-bit software-visible read word.
  localparam int VALID_BIT = 31;
  localparam int DATA_LSB  = 16;
  localparam int TS_LSB    = 0;

  typedef struct packed {
    logic [CAP_DATA_W-1:0] data;
    logic [CAP_TS_W-1:0]   ts;
  } cap_entry_t;

endpackage

// File: rtl/prism_cap_fifo.sv
// Generic synchronous FIFO with an explicit occupancy counter and a combinational head.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module prism_cap_fifo #(
  parameter int WIDTH = 27,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             pop_ok, push_ok, wr_en;

  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q != FULL_CNT) || pop_ok);
    wr_en    = push_ok && !clr;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

  assign dout       = mem_q[rd_ptr_q];
  assign count      = count_q;
  assign count_next = count_d;
  assign full       = (count_q == FULL_CNT);
  assign empty      = (count_q == '0);

endmodule

// File: rtl/prism_out_capture.sv
// Timestamps every change of the PRISM output bus and queues {data, ts} events
// for software to pop, with a threshold/overflow interrupt.
module prism_out_capture
  import prism_cap_pkg::*;
#(
  parameter int DATA_W = 11,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [$clog2(DEPTH):0] thresh,
  input  logic [DATA_W-1:0]      out_data,
  input  logic                   rd_pop,
  output logic [31:0]            rd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   irq
);

  logic [DATA_W-1:0]      prev_q, prev_d;
  logic [TS_W-1:0]        ts_q, ts_d;
  logic                   overflow_q, overflow_d;
  logic                   irq_q, irq_d;
  logic                   evt, drop;
  logic [$clog2(DEPTH):0] count_next;
  cap_entry_t             push_entry, head;

  // prev tracks the bus even while disabled, so enabling never sees a stale value.
  assign evt        = enable && (out_data != prev_q);
  assign drop       = evt && full && !rd_pop;
  assign push_entry = '{data: out_data, ts: ts_q};

  prism_cap_fifo #(
    .WIDTH($bits(cap_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .clr        (clear),
    .push       (evt),
    .pop        (rd_pop),
    .din        (push_entry),
    .dout       (head),
    .count      (count),
    .count_next (count_next),
    .full       (full),
    .empty      (empty)
  );

  always_comb begin
    prev_d     = out_data;
    ts_d       = ts_q;
    overflow_d = overflow_q;
    if (clear) begin
      ts_d       = '0;
      overflow_d = 1'b0;
    end else begin
      if (enable) ts_d = ts_q + TS_W'(1);
      if (drop)   overflow_d = 1'b1;
    end
    irq_d = ((|thresh) && (count_next >= thresh)) || overflow_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= '0;
      ts_q       <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      ts_q       <= ts_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    rd_data = '0;
    if (!empty) begin
      rd_data[VALID_BIT]               = 1'b1;
      rd_data[DATA_LSB +: CAP_DATA_W]  = head.data;
      rd_data[TS_LSB +: CAP_TS_W]      = head.ts;
    end
  end

  assign overflow = overflow_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_prism_out_capture.sv
// Directed bench for prism_out_capture: a reference queue predicts every entry
// and the flag state, and the DUT head is compared against it on each pop.
module tb_prism_out_capture;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic [3:0]  thresh = '0;
  logic [10:0] out_data = '0;
  logic        rd_pop = 1'b0;
  logic [31:0] rd_data;
  logic [3:0]  count;
  logic        empty, full, overflow, irq;

  int passed = 0;
  int total  = 0;

  logic [26:0] m_q[$];
  logic [15:0] m_ts = '0;
  logic [10:0] m_prev = '0;
  logic        m_ovf = 1'b0;
  logic        m_irq = 1'b0;

  prism_out_capture #(.DATA_W(11), .TS_W(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear), .thresh(thresh),
    .out_data(out_data), .rd_pop(rd_pop), .rd_data(rd_data), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] m_head();
    if (m_q.size() == 0) return 32'h0;
    return {1'b1, 4'b0, m_q[0]};
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".count"},    32'(count),    32'(m_q.size()));
    chk({tag, ".empty"},    32'(empty),    32'(m_q.size() == 0));
    chk({tag, ".full"},     32'(full),     32'(m_q.size() == DEPTH));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, ".irq"},      32'(irq),      32'(m_irq));
    chk({tag, ".rd_data"},  rd_data,       m_head());
  endtask

  // Advance the reference by one edge using the inputs the DUT is about to sample.
  task automatic tick();
    logic evt;
    evt = enable && (out_data !== m_prev);
    if (clear) begin
      m_q.delete();
      m_ts  = '0;
      m_ovf = 1'b0;
    end else begin
      if (rd_pop && m_q.size() > 0) void'(m_q.pop_front());
      if (evt) begin
        if (m_q.size() < DEPTH) m_q.push_back({out_data, m_ts});
        else m_ovf = 1'b1;
      end
      if (enable) m_ts = m_ts + 16'd1;
    end
    m_prev = out_data;
    m_irq  = ((thresh != 0) && (m_q.size() >= int'(thresh))) || m_ovf;
    @(posedge clk);
    #1;
  endtask

  task automatic change(input logic [10:0] v);
    out_data = v;
    tick();
  endtask

  task automatic pop_checked(input string tag);
    chk({tag, ".head"}, rd_data, m_head());
    rd_pop = 1'b1;
    tick();
    rd_pop = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    // Reset
    #1 rst = 1'b1;
    #2;
    check_state("reset");
    @(posedge clk); #1;
    enable = 1'b1;
    rst    = 1'b0;

    // First event at cycle 10 carries ts 10
    repeat (10) tick();
    change(11'h005);
    chk("first.rd_data", rd_data, 32'h8005_000A);
    check_state("first");
    pop_checked("first_pop");

    // Nine changes into an 8-deep FIFO: ninth is dropped
    for (int i = 0; i < 9; i++) change(11'(12'h100 + i));
    check_state("overfill");
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("order%0d.data", i), 32'(rd_data[26:16]), 32'(12'h100 + i));
      pop_checked($sformatf("order%0d", i));
    end
    rd_pop = 1'b1;
    tick();
    rd_pop = 1'b0;
    check_state("pop_empty");

    // Full FIFO with simultaneous push and pop
    do_clear();
    check_state("clear1");
    for (int i = 0; i < 8; i++) change(11'(12'h200 + i));
    out_data = 11'h2AA;
    rd_pop   = 1'b1;
    tick();
    rd_pop   = 1'b0;
    chk("full_pushpop.count", 32'(count), 32'd8);
    chk("full_pushpop.ovf",   32'(overflow), 32'd0);
    chk("full_pushpop.head",  32'(rd_data[26:16]), 32'h201);
    check_state("full_pushpop");

    // Threshold interrupt
    do_clear();
    thresh = 4'd3;
    change(11'h300);
    change(11'h301);
    chk("thresh2.irq", 32'(irq), 32'd0);
    change(11'h302);
    chk("thresh3.irq", 32'(irq), 32'd1);
    pop_checked("thresh_pop");
    chk("thresh_pop.irq", 32'(irq), 32'd0);
    thresh = 4'd0;

    // Timestamp wrap
    do_clear();
    repeat (65535) tick();
    tick();
    change(11'h3C3);
    chk("wrap.ts", 32'(rd_data[15:0]), 32'h0);
    check_state("wrap");

    // Disabled capture freezes ts and records nothing; re-enable is quiet
    enable = 1'b0;
    for (int i = 0; i < 4; i++) change(11'(12'h050 + i));
    check_state("disabled");
    enable = 1'b1;
    tick();
    check_state("reenable");
    change(11'h077);
    pop_checked("wrap_pop");
    chk("frozen.ts", 32'(rd_data[15:0]), 32'd2);
    check_state("frozen");

    // Clear beats a simultaneous push while full and overflowed
    do_clear();
    for (int i = 0; i < 9; i++) change(11'(12'h400 + i));
    check_state("prefill");
    out_data = 11'h4FF;
    clear    = 1'b1;
    tick();
    clear    = 1'b0;
    chk("clear_full.count",   32'(count), 32'd0);
    chk("clear_full.empty",   32'(empty), 32'd1);
    chk("clear_full.ovf",     32'(overflow), 32'd0);
    chk("clear_full.irq",     32'(irq), 32'd0);
    chk("clear_full.rd_data", rd_data, 32'h0);

    // Asynchronous reset mid-fill
    for (int i = 0; i < 3; i++) change(11'(12'h500 + i));
    check_state("midfill");
    rst = 1'b1;
    #1;
    m_q.delete();
    m_ts   = '0;
    m_prev = '0;
    m_ovf  = 1'b0;
    m_irq  = 1'b0;
    check_state("async_rst");
    #3;
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
